// File: rtl/fp_exp_bias_sub.sv
// fp_exp_bias_sub: two-stage exponent de-bias and saturating classification with valid/ready flow control
module fp_exp_bias_sub #(
  parameter int EW = 5,
  parameter int BIAS = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW:0]   sum_in,
  input  logic          norm_inc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] exp_out,
  output logic          ovf,
  output logic          unf
);
  localparam logic [EW+1:0] neg_bias = ~(EW+2)'(BIAS) + (EW+2)'(1);
  localparam logic [EW+1:0] exp_max = (EW+2)'((1 << EW) - 1);
  logic          s1_valid;
  logic [EW+1:0] s1_t;
  logic          s2_load;
  logic          s1_load;
  logic [EW+1:0] t_next;
  logic          t_unf;
  logic          t_ovf;
  assign s2_load  = s1_valid & (!out_valid | out_ready);
  assign in_ready = !s1_valid | s2_load;
  assign s1_load  = in_valid & in_ready;
  assign t_next   = (EW+2)'(sum_in) + (EW+2)'(norm_inc) + neg_bias;
  assign t_unf    = $signed(s1_t) <= 0;
  assign t_ovf    = $signed(s1_t) >= $signed(exp_max);
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_t      <= '0;
      out_valid <= 1'b0;
      exp_out   <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      if (s1_load) s1_t <= t_next;
      s1_valid <= s1_load | (s1_valid & !s2_load);
      if (s2_load) begin
        exp_out <= t_unf ? '0 : t_ovf ? exp_max[EW-1:0] : s1_t[EW-1:0];
        ovf     <= !t_unf & t_ovf;
        unf     <= t_unf;
      end
      out_valid <= s2_load | (out_valid & !out_ready);
    end
  end
endmodule
